// File: rtl/multibyte_add_sequencer_if.sv
// Request/adder bundle for multibyte_add_sequencer.
// MULTIBYTE_ADD_SUB_EN adds the 'sub' request bit.
interface multibyte_add_sequencer_if #(
    parameter int unsigned BYTES = 4
);
    localparam int unsigned W = 8 * BYTES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin_in;
`ifdef MULTIBYTE_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout_out;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_s;
    logic         add_cout;

    // slave: the sequencer; master: the requester plus the external 8-bit adder
    modport slave (
`ifdef MULTIBYTE_ADD_SUB_EN
        input  sub,
`endif
        input  start, op_a, op_b, cin_in, add_s, add_cout,
        output busy, done, result, cout_out, add_a, add_b, add_cin
    );

    modport master (
`ifdef MULTIBYTE_ADD_SUB_EN
        output sub,
`endif
        output start, op_a, op_b, cin_in, add_s, add_cout,
        input  busy, done, result, cout_out, add_a, add_b, add_cin
    );
endinterface

// File: rtl/multibyte_add_sequencer.sv
// Multi-byte add on a single external 8-bit adder, LSB byte first, carry chained.
// Optional subtract mode via MULTIBYTE_ADD_SUB_EN.
module multibyte_add_sequencer #(
    parameter int unsigned BYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    multibyte_add_sequencer_if.slave bus
);
    localparam int unsigned W  = 8 * BYTES;
    localparam int unsigned IW = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry_reg;
    logic [IW-1:0] idx;

    logic [W-1:0]  b_next;
    logic          carry_next;

    // Subtraction is A + ~B + 1: invert B and force the initial carry.
    always_comb begin
        b_next     = bus.op_b;
        carry_next = bus.cin_in;
`ifdef MULTIBYTE_ADD_SUB_EN
        if (bus.sub) begin
            b_next     = ~bus.op_b;
            carry_next = 1'b1;
        end
`endif
    end

    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        if (state == RUN) begin
            bus.add_a   = a_reg[{idx, 3'b000} +: 8];
            bus.add_b   = b_reg[{idx, 3'b000} +: 8];
            bus.add_cin = carry_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            carry_reg    <= 1'b0;
            idx          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.cout_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.op_a;
                        b_reg     <= b_next;
                        carry_reg <= carry_next;
                        idx       <= '0;
                        bus.busy  <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[{idx, 3'b000} +: 8] <= bus.add_s;
                    carry_reg                   <= bus.add_cout;
                    idx                         <= idx + 1'b1;
                    if (idx == IW'(BYTES - 1)) begin
                        // Top byte arrives this edge, so splice it onto the stored lower bytes.
                        bus.result   <= {bus.add_s, sum_reg[W-9:0]};
                        bus.cout_out <= bus.add_cout;
                        bus.done     <= 1'b1;
                        idx          <= '0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer (BYTES=4) with a behavioural 8-bit adder.
// Define MULTIBYTE_ADD_SUB_EN to also exercise subtract mode.
module tb_multibyte_add_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
`ifdef MULTIBYTE_ADD_SUB_EN
    logic sub_req = 1'b0;
`endif

    always #5 clk = ~clk;

    multibyte_add_sequencer_if #(.BYTES(4)) bus ();

    multibyte_add_sequencer #(.BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic pulse_busy,
                         input logic [31:0] prev_r, input logic prev_c,
                         input logic [31:0] exp_r, input logic exp_c, input logic chk_cin);
        int   n     = 0;
        int   nbusy = 0;
        logic held  = 1'b1;
        logic cins[4];
        bus.start  = 1'b1;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.cin_in = ci;
`ifdef MULTIBYTE_ADD_SUB_EN
        bus.sub    = sub_req;
`endif
        tick();
        bus.start  = 1'b0;
        bus.op_a   = ~a;
        bus.op_b   = ~b;
        bus.cin_in = ~ci;
        for (int i = 0; i < 4; i++) cins[i] = 1'bx;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.busy === 1'b1) nbusy++;
            if (bus.result !== prev_r || bus.cout_out !== prev_c) held = 1'b0;
            if (n < 4) cins[n] = bus.add_cin;
            bus.start = pulse_busy && (n == 1);
            tick();
            n++;
        end
        if (bus.busy === 1'b1) nbusy++;
        bus.start = pulse_busy;
        tick();
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_busy_cycles"}, 64'(nbusy), 64'd5);
        check({tag, "_held"}, 64'(held), 64'd1);
        check({tag, "_result"}, 64'(bus.result), 64'(exp_r));
        check({tag, "_cout"}, 64'(bus.cout_out), 64'(exp_c));
        check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_idle_done"}, 64'(bus.done), 64'd0);
        if (chk_cin) begin
            check({tag, "_cin_run1"}, 64'(cins[0]), 64'd0);
            check({tag, "_cin_run2"}, 64'(cins[1]), 64'd1);
            check({tag, "_cin_run3"}, 64'(cins[2]), 64'd1);
            check({tag, "_cin_run4"}, 64'(cins[3]), 64'd1);
        end
        if (pulse_busy) begin
            tick();
            check({tag, "_no_queue_busy"}, 64'(bus.busy), 64'd0);
            check({tag, "_no_queue_done"}, 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        int   first  = 0;
        int   second = 0;
        int   pulses = 0;
        logic quiet  = 1'b1;

        bus.start  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.cin_in = 1'b0;
`ifdef MULTIBYTE_ADD_SUB_EN
        bus.sub    = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_cout", 64'(bus.cout_out), 64'd0);
        check("rst_add_a", 64'(bus.add_a), 64'd0);
        check("rst_add_b", 64'(bus.add_b), 64'd0);
        check("rst_add_cin", 64'(bus.add_cin), 64'd0);

        do_op("alt", 32'h55555555, 32'hAAAAAAAA, 1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
        do_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b1);
        do_op("cin_wrap", 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        do_op("plain", 32'h66666666, 32'h11111111, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h77777777, 1'b0, 1'b0);

        // start held high: done pulses expected at edges 4 and 10 after the first accept
        bus.start  = 1'b1;
        bus.op_a   = 32'h80000000;
        bus.op_b   = 32'h80000001;
        bus.cin_in = 1'b0;
        tick();
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
        end
        bus.start = 1'b0;
        check("b2b_first_done", 64'(first), 64'd4);
        check("b2b_second_done", 64'(second), 64'd10);
        check("b2b_pulses", 64'(pulses), 64'd2);
        check("b2b_result", 64'(bus.result), 64'h00000001);
        check("b2b_cout", 64'(bus.cout_out), 64'd1);
        tick();
        check("b2b_stop_busy", 64'(bus.busy), 64'd0);

        bus.start  = 1'b1;
        bus.op_a   = 32'h11111111;
        bus.op_b   = 32'h22222222;
        bus.cin_in = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        check("run2_add_a", 64'(bus.add_a), 64'h11);
        check("run2_add_b", 64'(bus.add_b), 64'h22);
        check("run2_add_cin", 64'(bus.add_cin), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_cout", 64'(bus.cout_out), 64'd0);
        check("abort_add_a", 64'(bus.add_a), 64'd0);
        check("abort_add_b", 64'(bus.add_b), 64'd0);
        check("abort_add_cin", 64'(bus.add_cin), 64'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        check("abort_quiet", 64'(quiet), 64'd1);

`ifdef MULTIBYTE_ADD_SUB_EN
        sub_req = 1'b1;
        do_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("sub_noborrow", 32'h00000100, 32'h00000001, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 32'h000000FF, 1'b1, 1'b0);
        sub_req = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
